// File: rtl/alu_serial_driver.sv
// alu_serial_driver
//
// Bit-serial sequencer that drives a single ALU1 bit slice for WIDTH cycles
// to build a WIDTH-bit result. It is a smaller-area alternative to a full
// parallel ALU16 and sits between the CPU datapath and one ALU1 instance.
//
// Operands are shifted into the slice LSB-first. The slice carry-in comes
// from a registered carry, and result bits are collected into a shift
// register. The driver itself resolves SLT (sign of A-B corrected by
// overflow), SRA/SLL (iterative one-bit shifts), and the CarryOut, Overflow
// and Zero flags.
//
// Ports
//   Clock           rising-edge clock
//   Reset           synchronous, active-high
//   start           request, only sampled while idle
//   A, B            operands; B[3:0] is the shift amount for SRA/SLL
//   Op              000 AND, 001 SLT, 010 OR, 011 XOR, 100 ADD/SUB,
//                   101 ADDI, 110 SRA, 111 SLL
//   Bnegate         invert B inside the slice (subtract when Op=100)
//   slice_result    Result bit returned by ALU1
//   slice_carryout  CarryOut bit returned by ALU1
//   slice_a/b/cin   operand bits and carry-in presented to ALU1
//   slice_bnegate   Bnegate presented to ALU1
//   slice_less      Less input of ALU1, tied low
//   slice_op        operation presented to ALU1
//   busy            high while an operation is in flight (incl. DONE)
//   done            one-cycle pulse when Result/flags become valid
//   Result          result, held until replaced by the next completion
//   CarryOut        final carry for arithmetic ops, else 0
//   Overflow        signed overflow for arithmetic ops, else 0
//   Zero            Result == 0 (registered with the result)

module alu_serial_driver #(
  parameter int WIDTH = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       Op,
  input  logic             Bnegate,
  input  logic             slice_result,
  input  logic             slice_carryout,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic             slice_bnegate,
  output logic             slice_less,
  output logic [2:0]       slice_op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut,
  output logic             Overflow,
  output logic             Zero
);

  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

  localparam logic [2:0] OP_SLT  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_ADDI = 3'b101;
  localparam logic [2:0] OP_SLL  = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [IDXW-1:0]  idx;
  logic [IDXW-1:0]  cnt;
  logic [2:0]       op_r;
  logic [2:0]       slice_op_r;
  logic             bneg_r;

  logic [2:0]       map_op;
  logic             map_bneg;
  logic             is_shift_op;
  logic [WIDTH-1:0] final_res;
  logic             cin15;
  logic             final_ovf;
  logic             slt_less;

  // ADDI runs as a plain add in the slice. SLT runs as a forced subtract,
  // so its sign bit can be examined at the end.
  always_comb begin
    map_op   = Op;
    map_bneg = Bnegate;
    if (Op == OP_ADDI) begin
      map_op = OP_ADD;
    end else if (Op == OP_SLT) begin
      map_op   = OP_ADD;
      map_bneg = 1'b1;
    end
  end

  assign is_shift_op = (Op[2:1] == 2'b11);

  // During the last RUN cycle the slice outputs carry the MSB result and the
  // final carry. The current registered carry is the carry into the MSB.
  // Flags are formed from these values directly at the completing edge.
  assign final_res = {slice_result, res_sh[WIDTH-1:1]};
  assign cin15     = carry;
  assign final_ovf = cin15 ^ slice_carryout;
  assign slt_less  = slice_result ^ final_ovf;

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          next_state = is_shift_op ? SHIFT : RUN;
        end
      end
      RUN: begin
        if (idx == LAST_IDX) begin
          next_state = DONE;
        end
      end
      SHIFT: begin
        if (cnt == '0) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output decode. Slice inputs are held at zero outside RUN so the slice
  // does not toggle while unused.
  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    slice_a       = 1'b0;
    slice_b       = 1'b0;
    slice_cin     = 1'b0;
    slice_bnegate = 1'b0;
    slice_op      = 3'b000;
    unique case (state)
      RUN: begin
        busy          = 1'b1;
        slice_a       = a_sh[0];
        slice_b       = b_sh[0];
        slice_cin     = carry;
        slice_bnegate = bneg_r;
        slice_op      = slice_op_r;
      end
      SHIFT: begin
        busy = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign slice_less = 1'b0;

  // Datapath.
  // In SHIFT, a_sh doubles as the shift accumulator and cnt counts the
  // remaining one-bit steps.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      carry      <= 1'b0;
      idx        <= '0;
      cnt        <= '0;
      op_r       <= 3'b000;
      slice_op_r <= 3'b000;
      bneg_r     <= 1'b0;
      Result     <= '0;
      CarryOut   <= 1'b0;
      Overflow   <= 1'b0;
      Zero       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sh       <= A;
            b_sh       <= B;
            res_sh     <= '0;
            op_r       <= Op;
            slice_op_r <= map_op;
            bneg_r     <= map_bneg;
            carry      <= map_bneg;
            idx        <= '0;
            cnt        <= B[IDXW-1:0];
          end
        end
        RUN: begin
          res_sh <= final_res;
          carry  <= slice_carryout;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          idx    <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            unique case (op_r)
              OP_ADD, OP_ADDI: begin
                Result   <= final_res;
                CarryOut <= slice_carryout;
                Overflow <= final_ovf;
                Zero     <= (final_res == '0);
              end
              OP_SLT: begin
                Result   <= {{(WIDTH-1){1'b0}}, slt_less};
                CarryOut <= 1'b0;
                Overflow <= 1'b0;
                Zero     <= ~slt_less;
              end
              default: begin
                Result   <= final_res;
                CarryOut <= 1'b0;
                Overflow <= 1'b0;
                Zero     <= (final_res == '0);
              end
            endcase
          end
        end
        SHIFT: begin
          if (cnt == '0) begin
            Result   <= a_sh;
            CarryOut <= 1'b0;
            Overflow <= 1'b0;
            Zero     <= (a_sh == '0);
          end else begin
            if (op_r == OP_SLL) begin
              a_sh <= {a_sh[WIDTH-2:0], 1'b0};
            end else begin
              a_sh <= {a_sh[WIDTH-1], a_sh[WIDTH-1:1]};
            end
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          carry <= carry;
        end
      endcase
    end
  end

endmodule
